// File: rtl/clk_rst_ctrl_pkg.sv
// Shared state encodings, reset-cause codes and helpers for the clock/reset sequencer.
package clk_rst_ctrl_pkg;

    localparam int unsigned ST_W = 3;

    localparam logic [ST_W-1:0] ST_HOLD      = 3'd0;
    localparam logic [ST_W-1:0] ST_STABLE    = 3'd1;
    localparam logic [ST_W-1:0] ST_PERIPH_UP = 3'd2;
    localparam logic [ST_W-1:0] ST_RUN       = 3'd3;
    localparam logic [ST_W-1:0] ST_SOFT      = 3'd4;

    localparam logic [1:0] RC_PIN  = 2'b01;
    localparam logic [1:0] RC_SOFT = 2'b10;

    // Peripherals stay in reset until debounce completes, and throughout a soft reset.
    function automatic logic periph_held(input logic [ST_W-1:0] st);
        return (st == ST_HOLD) || (st == ST_STABLE) || (st == ST_SOFT);
    endfunction

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/clk_rst_ctrl_if.sv
// Reset/clock-enable distribution bundle between the sequencer and its consumers.
interface clk_rst_ctrl_if #(
    parameter int unsigned N_CE  = 3,
    parameter int unsigned CNT_W = 32
);
    logic              soft_rst_req;
    logic              periph_rst;
    logic              cpu_rst;
    logic [N_CE-1:0]   ce;
    logic [CNT_W-1:0]  tick_cnt;
    logic [1:0]        rst_cause;

    modport master (
        input  soft_rst_req,
        output periph_rst,
        output cpu_rst,
        output ce,
        output tick_cnt,
        output rst_cause
    );

    modport slave (
        output soft_rst_req,
        input  periph_rst,
        input  cpu_rst,
        input  ce,
        input  tick_cnt,
        input  rst_cause
    );
endinterface

// File: rtl/clk_rst_ctrl_reset_sync.sv
// Two-flop reset synchroniser: asserts asynchronously, releases two edges after reset_n rises.
module reset_sync (
    input  logic clk,
    input  logic reset_n,
    output logic sync_out
);
    logic meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta     <= 1'b0;
            sync_out <= 1'b0;
        end else begin
            meta     <= 1'b1;
            sync_out <= meta;
        end
    end
endmodule

// File: rtl/clk_rst_ctrl.sv
// Staged reset sequencer: debounced pin release, peripheral-then-CPU release,
// soft reset handling, free-running tick counter and nested clock-enable strobes.
module clk_rst_ctrl
    import clk_rst_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CPU_DELAY       = 8,
    parameter int unsigned SOFT_LEN        = 4,
    parameter int unsigned CNT_W           = 32,
    parameter int unsigned N_CE            = 3,
    parameter int unsigned CE_BASE         = 1
) (
    input  logic           clk,
    input  logic           reset_n,
    clk_rst_ctrl_if.master bus
);

    localparam int unsigned PH_MAX = max3(DEBOUNCE_CYCLES, CPU_DELAY, SOFT_LEN);
    localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    localparam logic [PH_W-1:0] DEB_LAST  = PH_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PH_W-1:0] CPU_LAST  = PH_W'(CPU_DELAY - 1);
    localparam logic [PH_W-1:0] SOFT_LAST = PH_W'(SOFT_LEN - 1);

    logic              sync_out;
    logic [ST_W-1:0]   state, state_nxt;
    logic [PH_W-1:0]   cnt, cnt_nxt;
    logic [1:0]        cause_nxt;
    logic              periph_nxt;
    logic              cpu_nxt;
    logic [CNT_W-1:0]  tick_nxt;
    logic [N_CE-1:0]   ce_nxt;

    reset_sync u_reset_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .sync_out (sync_out)
    );

    // Next-state logic; the phase counter is shared by debounce, CPU delay and soft hold.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cause_nxt = bus.rst_cause;
        case (state)
            ST_HOLD: begin
                if (sync_out) begin
                    state_nxt = ST_STABLE;
                    cnt_nxt   = '0;
                end
            end
            ST_STABLE: begin
                if (cnt == DEB_LAST) begin
                    state_nxt = ST_PERIPH_UP;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + PH_W'(1);
                end
            end
            ST_PERIPH_UP: begin
                // A soft request on the last delay cycle beats the move to RUN.
                if (bus.soft_rst_req) begin
                    state_nxt = ST_SOFT;
                    cnt_nxt   = '0;
                    cause_nxt = RC_SOFT;
                end else if (cnt == CPU_LAST) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + PH_W'(1);
                end
            end
            ST_RUN: begin
                if (bus.soft_rst_req) begin
                    state_nxt = ST_SOFT;
                    cnt_nxt   = '0;
                    cause_nxt = RC_SOFT;
                end
            end
            ST_SOFT: begin
                if (cnt == SOFT_LAST) begin
                    state_nxt = ST_PERIPH_UP;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + PH_W'(1);
                end
            end
            default: begin
                state_nxt = ST_HOLD;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output values as they will appear after the next edge, so every output is a flop.
    always_comb begin
        periph_nxt = periph_held(state_nxt);
        cpu_nxt    = (state_nxt != ST_RUN);
        tick_nxt   = bus.tick_cnt + CNT_W'(1);
        if (bus.periph_rst || periph_nxt) begin
            tick_nxt = '0;
        end
    end

    for (genvar i = 0; i < N_CE; i++) begin : g_ce
        assign ce_nxt[i] = !periph_nxt && (&tick_nxt[CE_BASE+i-1:0]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_HOLD;
            cnt            <= '0;
            bus.periph_rst <= 1'b1;
            bus.cpu_rst    <= 1'b1;
            bus.tick_cnt   <= '0;
            bus.ce         <= '0;
            bus.rst_cause  <= RC_PIN;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            bus.periph_rst <= periph_nxt;
            bus.cpu_rst    <= cpu_nxt;
            bus.tick_cnt   <= tick_nxt;
            bus.ce         <= ce_nxt;
            bus.rst_cause  <= cause_nxt;
        end
    end

endmodule

// File: tb/tb_clk_rst_ctrl.sv
// Directed bench for clk_rst_ctrl: pin release, counter wrap, strobes, soft reset, conflicts and glitches.
module tb_clk_rst_ctrl;

    localparam int unsigned DEB  = 4;
    localparam int unsigned CPUD = 3;
    localparam int unsigned SLEN = 4;
    localparam int unsigned CW   = 8;
    localparam int unsigned NCE  = 3;
    localparam int unsigned CEB  = 1;

    logic clk = 1'b0;
    logic reset_n;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   exp_tick;

    always #5 clk = ~clk;

    clk_rst_ctrl_if #(.N_CE(NCE), .CNT_W(CW)) bus ();

    clk_rst_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .CPU_DELAY       (CPUD),
        .SOFT_LEN        (SLEN),
        .CNT_W           (CW),
        .N_CE            (NCE),
        .CE_BASE         (CEB)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ce[i] fires when tick+1 is a multiple of 2^(CEB+i)
    function automatic logic [NCE-1:0] exp_ce(input int t);
        logic [NCE-1:0] r;
        r = '0;
        for (int i = 0; i < int'(NCE); i++)
            if (((t + 1) % (1 << (CEB + i))) == 0) r[i] = 1'b1;
        return r;
    endfunction

    // reset_n has just risen between edges; walk edges 1..10 of the staged release
    task automatic pin_release(input string tag, input bit soft_in_stable);
        for (int e = 1; e <= 10; e++) begin
            step();
            chk($sformatf("%s periph e%0d", tag, e), 32'(bus.periph_rst), 32'(e < 7));
            chk($sformatf("%s cpu e%0d", tag, e), 32'(bus.cpu_rst), 32'(e < 10));
            chk($sformatf("%s tick e%0d", tag, e), 32'(bus.tick_cnt), (e >= 7) ? 32'(e - 7) : 32'd0);
            chk($sformatf("%s ce e%0d", tag, e), 32'(bus.ce), (e >= 7) ? 32'(exp_ce(e - 7)) : 32'd0);
            chk($sformatf("%s cause e%0d", tag, e), 32'(bus.rst_cause), 32'h1);
            if (soft_in_stable && e == 3) bus.soft_rst_req = 1'b1;
            if (e == 7) bus.soft_rst_req = 1'b0;
        end
    endtask

    initial begin
        reset_n          = 1'b0;
        bus.soft_rst_req = 1'b0;
        step();
        step();
        chk("rst periph", 32'(bus.periph_rst), 32'h1);
        chk("rst cpu",    32'(bus.cpu_rst),    32'h1);
        chk("rst tick",   32'(bus.tick_cnt),   32'h0);
        chk("rst ce",     32'(bus.ce),         32'h0);
        chk("rst cause",  32'(bus.rst_cause),  32'h1);

        // pin release
        reset_n = 1'b1;
        pin_release("pin", 1'b0);

        // run through the 8-bit wrap, checking strobes every cycle
        exp_tick = 3;
        for (int k = 0; k < 260; k++) begin
            step();
            exp_tick = (exp_tick + 1) % 256;
            chk($sformatf("run tick k%0d", k), 32'(bus.tick_cnt), 32'(exp_tick));
            chk($sformatf("run ce k%0d", k), 32'(bus.ce), 32'(exp_ce(exp_tick)));
            chk($sformatf("run periph k%0d", k), 32'(bus.periph_rst), 32'h0);
            chk($sformatf("run cpu k%0d", k), 32'(bus.cpu_rst), 32'h0);
        end

        // one-cycle soft reset in RUN
        bus.soft_rst_req = 1'b1;
        step();
        bus.soft_rst_req = 1'b0;
        chk("soft periph", 32'(bus.periph_rst), 32'h1);
        chk("soft cpu",    32'(bus.cpu_rst),    32'h1);
        chk("soft tick",   32'(bus.tick_cnt),   32'h0);
        chk("soft ce",     32'(bus.ce),         32'h0);
        chk("soft cause",  32'(bus.rst_cause),  32'h2);
        for (int e = 1; e <= 7; e++) begin
            step();
            chk($sformatf("soft periph e%0d", e), 32'(bus.periph_rst), 32'(e < 4));
            chk($sformatf("soft cpu e%0d", e), 32'(bus.cpu_rst), 32'(e < 7));
            chk($sformatf("soft tick e%0d", e), 32'(bus.tick_cnt), (e >= 4) ? 32'(e - 4) : 32'd0);
            chk($sformatf("soft cause e%0d", e), 32'(bus.rst_cause), 32'h2);
        end

        // soft request on the final PERIPH_UP cycle wins over RUN
        bus.soft_rst_req = 1'b1;
        step();
        bus.soft_rst_req = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            step();
            chk($sformatf("conf cpu e%0d", e), 32'(bus.cpu_rst), 32'h1);
            chk($sformatf("conf periph e%0d", e), 32'(bus.periph_rst), 32'(e < 4));
        end
        bus.soft_rst_req = 1'b1;
        step();
        bus.soft_rst_req = 1'b0;
        chk("conf resoft periph", 32'(bus.periph_rst), 32'h1);
        chk("conf resoft cpu",    32'(bus.cpu_rst),    32'h1);
        chk("conf resoft cause",  32'(bus.rst_cause),  32'h2);
        step();
        step();
        chk("conf mid soft cpu", 32'(bus.cpu_rst), 32'h1);

        // pin reset in the middle of SOFT: immediate, cause back to pin
        reset_n = 1'b0;
        #1;
        chk("midsoft periph", 32'(bus.periph_rst), 32'h1);
        chk("midsoft cpu",    32'(bus.cpu_rst),    32'h1);
        chk("midsoft cause",  32'(bus.rst_cause),  32'h1);
        chk("midsoft tick",   32'(bus.tick_cnt),   32'h0);
        step();
        reset_n = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            step();
            chk($sformatf("deb periph e%0d", e), 32'(bus.periph_rst), 32'h1);
        end

        // 1 ns glitch with the debounce counter at 2 restarts the full sequence
        reset_n = 1'b0;
        #1;
        chk("glitch periph", 32'(bus.periph_rst), 32'h1);
        chk("glitch cpu",    32'(bus.cpu_rst),    32'h1);
        chk("glitch cause",  32'(bus.rst_cause),  32'h1);
        reset_n = 1'b1;
        pin_release("glitch", 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/clk_rst_ctrl.md
Name: clk_rst_ctrl

Overview:
- Parametrised clock-enable and reset sequencer for the SoC top.
- Replaces the fixed reset debounce plus power-of-two clock divider pair.
- Debounces and synchronises the board reset, then releases resets in stages: peripherals first, CPU later.
- Accepts a soft reset request (debug/CPU), generates N_CE one-cycle clock-enable strobes, and reports the last reset cause.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive synchronised-high cycles required before peripheral release (>=1)
CPU_DELAY, 8, cycles between peripheral release and CPU release (>=1)
SOFT_LEN, 4, cycles both resets are held for a soft reset (>=1)
CNT_W, 32, width of free-running tick counter
N_CE, 3, number of clock-enable strobes
CE_BASE, 1, log2 period of ce[0]; ce[i] period = 2^(CE_BASE+i); require CE_BASE>=1, CE_BASE+N_CE<=CNT_W

Ports:
clk  input  1  single system clock
reset_n  input  1  asynchronous active-low reset; assertion is immediate, deassertion is synchronised inside
soft_rst_req  input  1  synchronous soft reset request, level sampled each edge
periph_rst  output  1  active-high reset for peripherals (VGA, debug)
cpu_rst  output  1  active-high reset for CPU core
ce  output  N_CE  one-cycle clock-enable strobes
tick_cnt  output  CNT_W  free-running tick counter
rst_cause  output  2  01 = pin reset, 10 = soft reset; 00/11 reserved

Behaviour:
- Reset (reset_n low, asynchronous):
  - state HOLD, periph_rst=1, cpu_rst=1, tick_cnt=0, ce=0, rst_cause=01.
  - Both synchroniser flops cleared.
- Synchroniser: 2 flops, D=1, cleared asynchronously by reset_n. sync_out goes high 2 edges after release.
- State machine (registered, phase counter is shared):
  - HOLD: sync_out=1 -> STABLE, cnt=0.
  - STABLE: cnt increments; at cnt==DEBOUNCE_CYCLES-1 -> PERIPH_UP, cnt=0.
  - PERIPH_UP: cnt increments; at cnt==CPU_DELAY-1 -> RUN.
  - RUN: steady state.
  - SOFT: entered from PERIPH_UP or RUN when soft_rst_req=1; cnt=0, rst_cause<=10. At cnt==SOFT_LEN-1 -> PERIPH_UP, cnt=0.
- Resets are registered outputs:
  - periph_rst=1 in HOLD/STABLE/SOFT.
  - cpu_rst=1 in every state except RUN.
- Latency (edge 1 = first rising edge with reset_n high):
  - periph_rst falls after edge DEBOUNCE_CYCLES+3.
  - cpu_rst falls after edge DEBOUNCE_CYCLES+CPU_DELAY+3.
- Soft reset:
  - Both resets rise on the edge that samples the request.
  - soft_rst_req is ignored in HOLD/STABLE/SOFT; it is not queued.
  - A held request re-triggers SOFT when PERIPH_UP is re-entered.
  - soft_rst_req on the final PERIPH_UP count cycle: SOFT wins over RUN.
- reset_n low in any state, including mid-SOFT or mid-debounce:
  - immediate return to HOLD, rst_cause=01.
  - A glitch restarts the full debounce.
- tick_cnt:
  - Held 0 while periph_rst=1.
  - Otherwise increments by 1 per cycle, wraps modulo 2^CNT_W with no flag.
- ce[i]:
  - Equals periph_rst==0 AND tick_cnt[CE_BASE+i-1:0] all ones.
  - Exactly one cycle high per 2^(CE_BASE+i) cycles.
  - First pulse on the cycle tick_cnt reaches 2^(CE_BASE+i)-1.
  - Strobes nest: ce[i] high implies ce[j] high for all j<i.
- No combinational path from reset_n or soft_rst_req to periph_rst or cpu_rst, except asynchronous assertion via reset_n.

Decomposition:
- Shared package/header: state encodings (HOLD, STABLE, PERIPH_UP, RUN, SOFT) and rst_cause codes (RC_PIN=2'b01, RC_SOFT=2'b10).
- One sub-module: reset_sync (2-flop async-assert/sync-release synchroniser, ports clk, reset_n, sync_out).

Test Plan:
1. Pin release: DEBOUNCE_CYCLES=4, CPU_DELAY=3. Release reset_n before edge 1 -> periph_rst low after edge 7, cpu_rst low after edge 10, rst_cause=01, tick_cnt=0 at edge 7, then 1,2,3...
2. Glitch: pulse reset_n low for 1 ns during STABLE (cnt=2) -> immediate HOLD, both resets high, periph_rst falls 7 edges after the new release.
3. Clock enables: CE_BASE=1, N_CE=3, after release -> ce[0] every 2 cycles (tick_cnt odd), ce[1] every 4, ce[2] every 8 (first at tick_cnt=7); none while periph_rst=1.
4. Soft reset in RUN: soft_rst_req=1 for one cycle, SOFT_LEN=4 -> both resets high next edge, tick_cnt=0, rst_cause=10; periph_rst low 4 edges later, cpu_rst low 3 after that.
5. Conflict: soft_rst_req on the final PERIPH_UP cycle -> SOFT entered, cpu_rst never drops; request during STABLE -> ignored, rst_cause stays 01.
6. Wrap: CNT_W=8 -> tick_cnt 255 -> 0 with no gap, ce pattern continuous across the wrap.
